// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and mux-select encodings for the cpu control FSM
//
// Purpose: single home for the controller state enum, instruction field
// constants and datapath select encodings used by cpu_fsm and its decoder.
// Ports: none (package).
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  // Instruction opcode field
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Instruction op field, MOV class
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // Instruction op field, ALU class
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // One-hot register-file select
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // Writeback mux select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/cpu_fsm_outputs.sv
// rtl/cpu_fsm_outputs.sv - combinational state+instruction to control-signal decoder
//
// Purpose: Moore output decode for cpu_fsm. Inputs are all registered in the
// parent, so outputs only change after a clock edge.
// Ports:
//   state       - current controller state
//   opcode, op  - latched instruction fields
//   w           - high only in WAIT
//   nsel, vsel  - register select (one-hot) and writeback mux select
//   loada..loads, asel, write - datapath enables
module cpu_fsm_outputs
  import cpu_pkg::*;
(
  input  state_t      state,
  input  logic [2:0]  opcode,
  input  logic [1:0]  op,
  output logic        w,
  output logic [2:0]  nsel,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        write
);

  logic is_cmp;
  logic is_mov_reg;

  assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);

  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_NONE;
    vsel  = VSEL_C;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    write = 1'b0;
    case (state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        // CMP only updates status; MOV reg passes B through with A zeroed
        loadc = ~is_cmp;
        loads = is_cmp;
        asel  = is_mov_reg;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_fsm.sv
// rtl/cpu_fsm.sv - multicycle instruction controller FSM
//
// Purpose: sequences MOV imm, MOV reg and ALU (ADD/CMP/AND/MVN) instructions
// through the datapath; holds the state and latched opcode/op registers.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   s           - start pulse, sampled only in WAIT
//   opcode, op  - instruction fields from the instruction register
//   w, nsel, vsel, loada, loadb, loadc, loads, asel, write - control outputs
module cpu_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [2:0]  opcode,
  input  logic [1:0]  op,
  output logic        w,
  output logic [2:0]  nsel,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        write
);

  state_t     state;
  logic [2:0] opcode_q;
  logic [1:0] op_q;

  // Instruction fields are captured once at start so the instruction
  // register may change freely while the instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
    end else begin
      case (state)
        S_WAIT: begin
          if (s) begin
            opcode_q <= opcode;
            op_q     <= op;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode_q == OPC_MOV && op_q == OP_MOV_IMM)
            state <= S_WRITE_IMM;
          else if (opcode_q == OPC_MOV && op_q == OP_MOV_REG)
            state <= S_GET_B;
          else if (opcode_q == OPC_ALU)
            state <= S_GET_A;
          else
            state <= S_WAIT;
        end
        S_WRITE_IMM: state <= S_WAIT;
        S_GET_A:     state <= S_GET_B;
        S_GET_B:     state <= S_ALU;
        S_ALU: begin
          if (opcode_q == OPC_ALU && op_q == OP_CMP)
            state <= S_WAIT;
          else
            state <= S_WRITE_REG;
        end
        S_WRITE_REG: state <= S_WAIT;
        default:     state <= S_WAIT;
      endcase
    end
  end

  cpu_fsm_outputs u_outputs (
    .state  (state),
    .opcode (opcode_q),
    .op     (op_q),
    .w      (w),
    .nsel   (nsel),
    .vsel   (vsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .asel   (asel),
    .write  (write)
  );

endmodule

// File: doc/cpu_fsm.md
CPU_FSM -- requirements
Module: cpu_fsm

Interface
REQ-001 SHALL: clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL: reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL: s, input, 1, start pulse; sampled only in WAIT.
REQ-004 SHALL: opcode, input, 3, instruction opcode field from the instruction register.
REQ-005 SHALL: op, input, 2, instruction op field from the instruction register.
REQ-006 SHALL: w, output, 1, high only in WAIT.
REQ-007 SHALL: nsel, output, 3, one-hot register select: 001=Rn, 010=Rd, 100=Rm, 000=none.
REQ-008 SHALL: vsel, output, 2, writeback mux select: 00=C, 01=PC, 10=sximm8, 11=mdata.
REQ-009 SHALL: loada/loadb/loadc/loads, output, 1 each, A/B/C/status register enables.
REQ-010 SHALL: asel, output, 1, 1 = zero the ALU A operand.
REQ-011 SHALL: write, output, 1, register-file write enable.

Function
REQ-012 SHALL: use Moore outputs decoded from the state and the latched opcode/op only; the default for every output except w is 0.
REQ-013 SHALL: use these states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
REQ-014 SHALL: in WAIT with s=1, latch opcode/op internally and go to DECODE; with s=0, stay in WAIT.
REQ-015 SHALL: ignore s outside WAIT; input opcode/op changes after latching have no effect.
REQ-016 SHALL: decode in DECODE as follows:
- 110/10 (MOV imm): go to WRITE_IMM.
- 110/00 (MOV reg): go to GET_B.
- 101/xx (ADD 00, CMP 01, AND 10, MVN 11): go to GET_A.
- Any other encoding: go to WAIT with no writes.
REQ-017 SHALL: in WRITE_IMM, drive nsel=001, vsel=10, write=1, then go to WAIT.
REQ-018 SHALL: in GET_A, drive nsel=001, loada=1, then go to GET_B.
REQ-019 SHALL: in GET_B, drive nsel=100, loadb=1, then go to ALU.
REQ-020 SHALL: in ALU, drive loadc=1 and asel=1 for MOV reg only.
- For CMP: drive loads=1 and loadc=0, then go to WAIT.
- Otherwise: go to WRITE_REG.
REQ-021 SHALL: in WRITE_REG, drive nsel=100... correction: drive nsel=010, vsel=00, write=1, then go to WAIT.
REQ-022 SHALL: meet these latencies from the s-sampling edge to w=1: MOV imm 3 cycles, MOV reg 5, CMP 5, ADD/AND/MVN 6, illegal 2.
REQ-023 SHALL: assert write in at most one cycle per instruction; write and any load never assert simultaneously.

Reset
REQ-024 SHALL: on reset=1 at posedge, enter WAIT regardless of state (including mid-instruction) and clear the latched opcode/op to 000/00.
REQ-025 SHALL: give reset priority over s and over all transitions; no write is issued in the reset cycle or the following cycle.

Structure
REQ-026 SHALL: place the state enum, the opcode/op constants, and the nsel/vsel encodings in shared package cpu_pkg.
REQ-027 SHALL: contain one sub-module, cpu_fsm_outputs: a combinational state+opcode-to-control-signal decoder; state and opcode registers stay in cpu_fsm.

Verification
REQ-028 SHALL: reset then idle, s=0 -> w=1 and all other outputs 0 indefinitely.
REQ-029 SHALL: MOV imm (110/10), s=1 one cycle -> DECODE, WRITE_IMM (nsel=001, vsel=10, write=1), w=1 on the 3rd edge.
REQ-030 SHALL: ADD (101/00) -> loada in cycle 2, loadb in cycle 3, loadc in cycle 4, write with nsel=010/vsel=00 in cycle 5, w=1 at edge 6.
REQ-031 SHALL: CMP (101/01) -> loads=1 in the ALU cycle, write never asserted, w=1 at edge 5.
REQ-032 SHALL: MOV reg (110/00) -> asel=1 in the ALU cycle, loada never asserted; an illegal opcode 000 returns to WAIT with no loads or writes.
REQ-033 SHALL: reset asserted during GET_B of ADD -> WAIT next edge, no write follows, and s toggled mid-instruction is ignored.
